// File: rtl/frame_crc_pkg.sv
// frame_crc_pkg: shared CRC constants and FSM state encoding for frame_crc_writer.
package frame_crc_pkg;

    // CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    // Residue left after running the CRC over a frame that carries its own CRC big-endian
    localparam logic [15:0] CRC_GOOD = 16'h0000;

    // Smallest legal frame: one payload byte plus two CRC bytes
    localparam int unsigned MIN_FRAME_LEN = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RECV = 2'd1;
    localparam state_t ST_DROP = 2'd2;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// crc16_ccitt_byte: combinational next-CRC for one byte, MSB of the byte first.
module crc16_ccitt_byte
    import frame_crc_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    // Bit-serial shift unrolled over the 8 data bits
    always_comb begin
        logic [15:0] c;
        logic        fb;
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data_i[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        crc_o = c;
    end

endmodule

// File: rtl/frame_crc_writer.sv
// frame_crc_writer: writes framed bytes into frame_fifo_late and closes every
// frame with exactly one commit (good) or rollback (bad CRC, length or FIFO overflow).
// Optional per-frame statistics counters are built when FRAME_CRC_STATS_EN is defined.
module frame_crc_writer
    import frame_crc_pkg::*;
#(
    parameter int DATAWIDTH = 8,    // CRC datapath is byte-wide; only 8 is meaningful
    parameter int MAXLEN    = 256,  // max frame length including the two CRC bytes
    parameter int LENWIDTH  = 9     // 2**LENWIDTH must exceed MAXLEN
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 in_eof,
    output logic [DATAWIDTH-1:0] fifo_wr_data,
    output logic                 fifo_we,
    output logic                 fifo_commit,
    output logic                 fifo_rollback,
    input  logic                 fifo_ovf,
    output logic                 frame_good,
    output logic                 frame_bad,
    output logic [15:0]          good_cnt,
    output logic [15:0]          bad_cnt
);

    localparam logic [LENWIDTH-1:0] MAXLEN_L = LENWIDTH'(MAXLEN);
    localparam logic [LENWIDTH-1:0] MINLEN_L = LENWIDTH'(MIN_FRAME_LEN);
    localparam logic [LENWIDTH-1:0] LEN_ONE  = LENWIDTH'(1);

    state_t               state_q, state_d;
    logic [15:0]          crc_q, crc_d;
    logic [LENWIDTH-1:0]  len_q, len_d;
    logic                 ovf_seen_q, ovf_seen_d;
    logic                 left_recv_q, left_recv_d;

    logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;
    logic                 we_q, we_d;
    logic                 commit_q, commit_d;
    logic                 rollback_q, rollback_d;

    logic [15:0]          crc_src;
    logic [15:0]          crc_upd;
    logic [LENWIDTH-1:0]  len_next;
    logic                 ovf_now;
    logic                 frame_ok;

    // A new frame always restarts from the init value, so IDLE feeds CRC_INIT
    assign crc_src  = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
    assign len_next = len_q + LEN_ONE;
    // An overflow pulse coincident with the eof byte must still spoil the frame
    assign ovf_now  = ovf_seen_q | fifo_ovf;
    assign frame_ok = (crc_upd == CRC_GOOD) && (len_next >= MINLEN_L) && !ovf_now;

    crc16_ccitt_byte u_crc (
        .crc_i  (crc_src),
        .data_i (in_data[7:0]),
        .crc_o  (crc_upd)
    );

    // Frame FSM: decides writes and the end-of-frame verdict one cycle ahead of the outputs
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        wr_data_d  = wr_data_q;
        we_d       = 1'b0;
        commit_d   = 1'b0;
        rollback_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Bytes without sof are stray and silently dropped
                if (in_valid && in_sof) begin
                    we_d      = 1'b1;
                    wr_data_d = in_data;
                    crc_d     = crc_upd;
                    len_d     = LEN_ONE;
                    if (in_eof) begin
                        // Single-byte frame can never hold a CRC
                        rollback_d = 1'b1;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // Abort: the new sof byte is not written, the open frame is rolled back
                        rollback_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (len_q == MAXLEN_L) begin
                        // Too long: reject now and swallow the rest of the frame
                        rollback_d = 1'b1;
                        state_d    = in_eof ? ST_IDLE : ST_DROP;
                    end else begin
                        we_d      = 1'b1;
                        wr_data_d = in_data;
                        crc_d     = crc_upd;
                        len_d     = len_next;
                        if (in_eof) begin
                            commit_d   = frame_ok;
                            rollback_d = !frame_ok;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (in_valid && in_eof) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Overflow tracking: armed during RECV and the cycle after leaving it, cleared by sof
    always_comb begin
        ovf_seen_d  = ovf_seen_q;
        left_recv_d = (state_q == ST_RECV) && (state_d != ST_RECV);
        if (fifo_ovf && ((state_q == ST_RECV) || left_recv_q)) begin
            ovf_seen_d = 1'b1;
        end
        if (in_valid && in_sof) begin
            ovf_seen_d = 1'b0;
        end
    end

    // State and registered FIFO-side outputs
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            ovf_seen_q  <= 1'b0;
            left_recv_q <= 1'b0;
            wr_data_q   <= '0;
            we_q        <= 1'b0;
            commit_q    <= 1'b0;
            rollback_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            ovf_seen_q  <= ovf_seen_d;
            left_recv_q <= left_recv_d;
            wr_data_q   <= wr_data_d;
            we_q        <= we_d;
            commit_q    <= commit_d;
            rollback_q  <= rollback_d;
        end
    end

    assign fifo_wr_data  = wr_data_q;
    assign fifo_we       = we_q;
    assign fifo_commit   = commit_q;
    assign fifo_rollback = rollback_q;
    // Verdict pulses share the commit/rollback flops so they are coincident by construction
    assign frame_good    = commit_q;
    assign frame_bad     = rollback_q;

`ifdef FRAME_CRC_STATS_EN
    logic [15:0] good_cnt_q, bad_cnt_q;

    // Saturating verdict counters, stepped on the same edge that raises frame_good/frame_bad
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            if (commit_d && (good_cnt_q != 16'hFFFF)) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (rollback_d && (bad_cnt_q != 16'hFFFF)) begin
                bad_cnt_q <= bad_cnt_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_crc_writer.sv
// tb_frame_crc_writer: directed frames with hand-computed verdicts, scoreboard-checked.
module tb_frame_crc_writer;

    typedef struct packed {
        logic       we;
        logic [7:0] data;
        logic       cm;
        logic       rb;
    } ev_t;

    logic clk = 1'b0;
    logic reset_l;

    // Default-parameter instance
    logic [7:0]  in_data;
    logic        in_valid, in_sof, in_eof, fifo_ovf;
    logic [7:0]  fifo_wr_data;
    logic        fifo_we, fifo_commit, fifo_rollback, frame_good, frame_bad;
    logic [15:0] good_cnt, bad_cnt;

    // MAXLEN=8 instance for the length-limit case
    logic [7:0]  in8_data;
    logic        in8_valid, in8_sof, in8_eof, fifo8_ovf;
    logic [7:0]  fifo8_wr_data;
    logic        fifo8_we, fifo8_commit, fifo8_rollback, frame8_good, frame8_bad;
    logic [15:0] good8_cnt, bad8_cnt;

    int checks = 0;
    int errors = 0;
    ev_t q0[$];
    ev_t q8[$];

    logic [7:0] msg_good  [16];
    logic [7:0] msg_bad   [16];
    logic [7:0] msg_short [16];

    always #5 clk = ~clk;

    frame_crc_writer dut (
        .clk(clk), .reset_l(reset_l), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_eof(in_eof), .fifo_wr_data(fifo_wr_data), .fifo_we(fifo_we),
        .fifo_commit(fifo_commit), .fifo_rollback(fifo_rollback), .fifo_ovf(fifo_ovf),
        .frame_good(frame_good), .frame_bad(frame_bad), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    frame_crc_writer #(.DATAWIDTH(8), .MAXLEN(8), .LENWIDTH(4)) dut8 (
        .clk(clk), .reset_l(reset_l), .in_data(in8_data), .in_valid(in8_valid),
        .in_sof(in8_sof), .in_eof(in8_eof), .fifo_wr_data(fifo8_wr_data), .fifo_we(fifo8_we),
        .fifo_commit(fifo8_commit), .fifo_rollback(fifo8_rollback), .fifo_ovf(fifo8_ovf),
        .frame_good(frame8_good), .frame_bad(frame8_bad), .good_cnt(good8_cnt), .bad_cnt(bad8_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic chk_ev(input string nm, input ev_t exp, input logic we, input logic [7:0] d,
                          input logic cm, input logic rb, input logic g, input logic b);
        checks++;
        if (we !== exp.we || (exp.we && d !== exp.data) || cm !== exp.cm || rb !== exp.rb ||
            g !== cm || b !== rb) begin
            errors++;
            $display("FAIL %s event: got we=%b data=%h commit=%b rollback=%b good=%b bad=%b want we=%b data=%h commit=%b rollback=%b",
                     nm, we, d, cm, rb, g, b, exp.we, exp.data, exp.cm, exp.rb);
        end
    endtask

    // Monitors: any FIFO strobe must match the next queued expectation
    always @(negedge clk) begin
        ev_t e;
        if (reset_l === 1'b1 && (fifo_we || fifo_commit || fifo_rollback)) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut unexpected: we=%b data=%h commit=%b rollback=%b",
                         fifo_we, fifo_wr_data, fifo_commit, fifo_rollback);
            end else begin
                e = q0.pop_front();
                chk_ev("dut", e, fifo_we, fifo_wr_data, fifo_commit, fifo_rollback, frame_good, frame_bad);
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (reset_l === 1'b1 && (fifo8_we || fifo8_commit || fifo8_rollback)) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 unexpected: we=%b data=%h commit=%b rollback=%b",
                         fifo8_we, fifo8_wr_data, fifo8_commit, fifo8_rollback);
            end else begin
                e = q8.pop_front();
                chk_ev("dut8", e, fifo8_we, fifo8_wr_data, fifo8_commit, fifo8_rollback, frame8_good, frame8_bad);
            end
        end
    end

    // Drive one byte for one cycle; queue the strobes it should produce one cycle later
    task automatic put(input bit s8, input logic [7:0] d, input logic sof, input logic eof,
                       input logic ovf, input logic xwe, input logic xcm, input logic xrb,
                       input bit push);
        ev_t e;
        @(posedge clk);
        #1;
        if (s8) begin
            in8_data = d; in8_valid = 1'b1; in8_sof = sof; in8_eof = eof; fifo8_ovf = ovf;
        end else begin
            in_data = d; in_valid = 1'b1; in_sof = sof; in_eof = eof; fifo_ovf = ovf;
        end
        if (push && (xwe || xcm || xrb)) begin
            e = '{we: xwe, data: d, cm: xcm, rb: xrb};
            if (s8) q8.push_back(e);
            else    q0.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; fifo_ovf = 1'b0;
            in8_valid = 1'b0; in8_sof = 1'b0; in8_eof = 1'b0; fifo8_ovf = 1'b0;
        end
    endtask

    // Whole frame: every byte written, verdict on the last byte's write
    task automatic frame(input bit s8, input logic [7:0] b [16], input int n, input int ovf_at,
                         input logic lcm, input logic lrb);
        for (int i = 0; i < n; i++) begin
            put(s8, b[i], i == 0, i == n - 1, i == ovf_at, 1'b1,
                (i == n - 1) & lcm, (i == n - 1) & lrb, 1'b1);
        end
        idle(3);
    endtask

    task automatic chk_stats(input string nm, input logic [15:0] g, input logic [15:0] b);
`ifdef FRAME_CRC_STATS_EN
        chk({nm, " good_cnt"}, {16'h0, good_cnt}, {16'h0, g});
        chk({nm, " bad_cnt"},  {16'h0, bad_cnt},  {16'h0, b});
`else
        chk({nm, " good_cnt"}, {16'h0, good_cnt}, 32'h0);
        chk({nm, " bad_cnt"},  {16'h0, bad_cnt},  32'h0);
`endif
    endtask

    initial begin
        // "123456789" has CRC-16/CCITT-FALSE 0x29B1; single byte 0x00 has 0xE1F0
        msg_good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        msg_bad   = msg_good;
        msg_bad[10] = 8'hB0;
        msg_short = '{8'h00, 8'hE1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        reset_l = 1'b0;
        in_data = '0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; fifo_ovf = 1'b0;
        in8_data = '0; in8_valid = 1'b0; in8_sof = 1'b0; in8_eof = 1'b0; fifo8_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset we",       {31'h0, fifo_we},       32'h0);
        chk("reset commit",   {31'h0, fifo_commit},   32'h0);
        chk("reset rollback", {31'h0, fifo_rollback}, 32'h0);
        chk("reset good",     {31'h0, frame_good},    32'h0);
        chk("reset bad",      {31'h0, frame_bad},     32'h0);
        chk("reset wr_data",  {24'h0, fifo_wr_data},  32'h0);
        chk_stats("reset", 16'd0, 16'd0);
        reset_l = 1'b1;
        idle(2);

        // Good 11-byte frame -> commit on the 11th write
        frame(1'b0, msg_good, 11, -1, 1'b1, 1'b0);
        // Corrupted CRC byte -> rollback on the 11th write
        frame(1'b0, msg_bad, 11, -1, 1'b0, 1'b1);
        // FIFO overflow during byte 5 -> rollback at eof
        frame(1'b0, msg_good, 11, 4, 1'b0, 1'b1);
        // sof+eof single byte: written, then rolled back in the same cycle
        put(1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        // Stray bytes in IDLE produce nothing
        put(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Minimum-length good frame
        frame(1'b0, msg_short, 3, -1, 1'b1, 1'b0);

        // Abort: sof at byte 4 rolls back without writing it, then IDLE drops non-sof bytes
        put(1'b0, 8'h31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        put(1'b0, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h36, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        frame(1'b0, msg_good, 11, -1, 1'b1, 1'b0);
        chk_stats("pre-reset", 16'd3, 16'd4);

        // Length limit on MAXLEN=8: 8 writes, rollback w/o write on byte 9, rest dropped
        for (int i = 0; i < 11; i++) begin
            put(1'b1, msg_good[i], i == 0, i == 10, 1'b0, i < 8, 1'b0, i == 8, 1'b1);
        end
        idle(3);
        frame(1'b1, msg_short, 3, -1, 1'b1, 1'b0);

        // Reset mid-frame: outputs clear immediately, last byte never seen
        put(1'b0, 8'h31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        put(1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        chk("pre-reset we", {31'h0, fifo_we}, 32'h1);
        reset_l = 1'b0;
        #1;
        chk("mid reset we",       {31'h0, fifo_we},       32'h0);
        chk("mid reset rollback", {31'h0, fifo_rollback}, 32'h0);
        chk("mid reset commit",   {31'h0, fifo_commit},   32'h0);
        chk("mid reset wr_data",  {24'h0, fifo_wr_data},  32'h0);
        idle(2);
        reset_l = 1'b1;
        idle(2);
        frame(1'b0, msg_good, 11, -1, 1'b1, 1'b0);
        chk_stats("post-reset", 16'd1, 16'd0);

        idle(5);
        chk("dut queue drained",  q0.size(), 32'h0);
        chk("dut8 queue drained", q8.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
